// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory port between the pipeline MEM stage and a
//   debug/loader master. It sits between the EX/MEM register outputs and
//   datamemory. The pipeline has priority. A starvation counter forces one
//   debug slot after MAX_WAIT denied debug cycles, and stalls the pipeline
//   for that slot.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   p_re/p_we/p_addr/p_wdata/p_funct3
//                               pipeline access request (MEM stage)
//   p_rdata                     pipeline read data, same cycle (0 when not granted)
//   p_stall                     freezes the front of the pipeline for a forced debug slot
//   d_req/d_we/d_addr/d_wdata   debug request, held until d_ready
//   d_ready                     debug request accepted this cycle
//   d_rvalid/d_rdata            debug read data, one cycle after acceptance
//   m_re/m_we/m_addr/m_wdata/m_funct3/m_rdata
//                               datamemory port (combinational read)
//   stat_stall_cnt/stat_dbg_cnt only when DMEM_ARB_STATS_EN is defined:
//                               saturating counts of stall cycles and debug grants
//
// Handshakes
//   Debug side: the master holds d_req and its payload stable until it sees
//   d_ready=1 in a cycle; the request is consumed at that clock edge. A
//   consumed read returns d_rvalid=1 for exactly the next cycle, with d_rdata
//   holding until the next debug read. There is no back-pressure on d_rvalid.
//   Pipeline side: the access always completes in its own cycle unless
//   p_stall=1, in which case the same access is presented again next cycle.
//
// Configuration macro: DMEM_ARB_STATS_EN (adds the statistics counters).

module dmem_port_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p_re,
  input  logic                  p_we,
  input  logic [DM_ADDRESS-1:0] p_addr,
  input  logic [DATA_W-1:0]     p_wdata,
  input  logic [2:0]            p_funct3,
  output logic [DATA_W-1:0]     p_rdata,
  output logic                  p_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DM_ADDRESS-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_re,
  output logic                  m_we,
  output logic [DM_ADDRESS-1:0] m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [2:0]            m_funct3,
  input  logic [DATA_W-1:0]     m_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]           stat_stall_cnt,
  output logic [15:0]           stat_dbg_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  // Count value at which one more denied cycle completes the MAX_WAIT-th denial.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic {
    NORM  = 1'b0,
    FORCE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic              p_req;
  logic              p_gnt;
  logic              d_gnt;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] d_rdata_q;

  assign p_req = p_re | p_we;

  // Arbitration and next state. Everything is held at zero while reset is
  // asserted so the memory sees no access during a mid-operation reset.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt;
    p_gnt      = 1'b0;
    d_gnt      = 1'b0;
    p_stall    = 1'b0;
    if (!reset) begin
      case (state_q)
        NORM: begin
          p_gnt = p_req;
          d_gnt = d_req & ~p_req;
          if (d_req && p_req) begin
            // The MAX_WAIT-th denial schedules the forced slot for the very
            // next cycle; the counter never goes past MAX_WAIT.
            if (wait_cnt >= LAST_WAIT) begin
              state_d    = FORCE;
              wait_cnt_d = '0;
            end else begin
              wait_cnt_d = wait_cnt + 1'b1;
            end
          end else begin
            // Either debug was granted or it is not asking: starvation resets.
            wait_cnt_d = '0;
          end
        end
        FORCE: begin
          // If debug withdrew its request, the slot falls back to the pipeline.
          d_gnt      = d_req;
          p_gnt      = p_req & ~d_req;
          p_stall    = p_req & d_req;
          state_d    = NORM;
          wait_cnt_d = '0;
        end
        default: begin
          state_d    = NORM;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  // Memory port steering by owner.
  always_comb begin
    m_re     = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_funct3 = 3'b000;
    if (p_gnt) begin
      // A simultaneous read and write is treated as a write.
      m_re     = p_re & ~p_we;
      m_we     = p_we;
      m_addr   = p_addr;
      m_wdata  = p_wdata;
      m_funct3 = p_funct3;
    end else if (d_gnt) begin
      m_re     = ~d_we;
      m_we     = d_we;
      m_addr   = d_addr;
      m_wdata  = d_wdata;
      m_funct3 = 3'b010;
    end
  end

  assign p_rdata = p_gnt ? m_rdata : '0;
  assign d_ready = d_gnt;

  // Read data registered at acceptance; masking with reset drops a response
  // that was already in flight when reset arrived.
  assign d_rvalid = d_rvalid_q & ~reset;
  assign d_rdata  = reset ? '0 : d_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NORM;
      wait_cnt   <= '0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt   <= wait_cnt_d;
      d_rvalid_q <= d_gnt & ~d_we;
      if (d_gnt && !d_we) begin
        d_rdata_q <= m_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_cnt <= '0;
      stat_dbg_cnt   <= '0;
    end else begin
      if (p_stall && stat_stall_cnt != 16'hFFFF) begin
        stat_stall_cnt <= stat_stall_cnt + 16'd1;
      end
      if (d_gnt && stat_dbg_cnt != 16'hFFFF) begin
        stat_dbg_cnt <= stat_dbg_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Directed bench for dmem_port_arbiter with a small word-addressed data
//   memory model attached to the m_* port. Inputs change 1 time unit after
//   the rising edge; outputs are sampled on the falling edge.

module tb_dmem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          p_re, p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [2:0]    p_funct3;
  logic [DW-1:0] p_rdata;
  logic          p_stall;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_re, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [2:0]    m_funct3;
  logic [DW-1:0] m_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stat_stall_cnt, stat_dbg_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // clock
  always #5 clk = ~clk;

  dmem_port_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .p_re(p_re), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_funct3(p_funct3), .p_rdata(p_rdata), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_funct3(m_funct3), .m_rdata(m_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_stall_cnt(stat_stall_cnt), .stat_dbg_cnt(stat_dbg_cnt)
`endif
  );

  // datamemory model: combinational read, write on clock edge
  logic [DW-1:0] mem [0:127];
  assign m_rdata = mem[m_addr[8:2]];
  always @(posedge clk) begin
    if (m_we) mem[m_addr[8:2]] <= m_wdata;
  end

  // driver / checking tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    p_re = 0; p_we = 0; p_addr = '0; p_wdata = '0; p_funct3 = 3'b010;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'(i) * 32'h0101_0101;
    mem[4]  = 32'hDEADBEEF;  // 0x010
    mem[8]  = 32'h12345678;  // 0x020
    mem[16] = 32'h0;         // 0x040

    // reset, with requests present: nothing may reach memory
    idle_inputs();
    reset = 1;
    tick(); tick();
    p_re = 1; p_addr = 9'h010; d_req = 1; d_addr = 9'h020;
    settle();
    chk("rst_m_re", 32'(m_re), 0);
    chk("rst_m_we", 32'(m_we), 0);
    chk("rst_m_addr", 32'(m_addr), 0);
    chk("rst_d_ready", 32'(d_ready), 0);
    chk("rst_p_stall", 32'(p_stall), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_state", 32'(dut.state_q), 0);
    chk("rst_wait_cnt", 32'(dut.wait_cnt), 0);
    tick();
    reset = 0;
    idle_inputs();

    // 1: pipeline read, same-cycle data
    p_re = 1; p_addr = 9'h010;
    settle();
    chk("t1_m_re", 32'(m_re), 1);
    chk("t1_m_addr", 32'(m_addr), 32'h010);
    chk("t1_p_rdata", p_rdata, 32'hDEADBEEF);
    chk("t1_p_stall", 32'(p_stall), 0);
    tick();

    // 2: debug read on an idle pipeline
    p_re = 0;
    d_req = 1; d_we = 0; d_addr = 9'h020;
    settle();
    chk("t2_d_ready", 32'(d_ready), 1);
    chk("t2_m_re", 32'(m_re), 1);
    chk("t2_m_funct3", 32'(m_funct3), 32'h2);
    chk("t2_p_rdata", p_rdata, 0);
    chk("t2_rvalid_early", 32'(d_rvalid), 0);
    tick();
    d_req = 0;
    settle();
    chk("t2_d_rvalid", 32'(d_rvalid), 1);
    chk("t2_d_rdata", d_rdata, 32'h12345678);
    chk("t2_d_ready_off", 32'(d_ready), 0);
    tick();
    settle();
    chk("t2_rvalid_pulse", 32'(d_rvalid), 0);
    chk("t2_rdata_hold", d_rdata, 32'h12345678);
    tick();

    // pipeline read+write together: write wins
    p_re = 1; p_we = 1; p_addr = 9'h080; p_wdata = 32'h0BADF00D;
    settle();
    chk("rw_m_we", 32'(m_we), 1);
    chk("rw_m_re", 32'(m_re), 0);
    tick();
    p_we = 0;
    settle();
    chk("rw_readback", p_rdata, 32'h0BADF00D);
    tick();

    // fresh reset so the statistics start from zero for scenario 3
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;

    // 3: starved debug write gets a forced slot on cycle 9
    p_re = 1; p_addr = 9'h010;
    d_req = 1; d_we = 1; d_addr = 9'h040; d_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("t3_deny_ready", 32'(d_ready), 0);
      chk("t3_deny_stall", 32'(p_stall), 0);
      chk("t3_deny_prdata", p_rdata, 32'hDEADBEEF);
      chk("t3_wait_cnt", 32'(dut.wait_cnt), 32'(i));
      tick();
    end
    settle();
    chk("t3_force_stall", 32'(p_stall), 1);
    chk("t3_force_ready", 32'(d_ready), 1);
    chk("t3_force_m_we", 32'(m_we), 1);
    chk("t3_force_m_re", 32'(m_re), 0);
    chk("t3_force_addr", 32'(m_addr), 32'h040);
    chk("t3_force_prdata", p_rdata, 0);
    chk("t3_force_cnt", 32'(dut.wait_cnt), 0);
    tick();
    d_req = 0;
    settle();
    chk("t3_after_stall", 32'(p_stall), 0);
    chk("t3_after_m_re", 32'(m_re), 1);
    chk("t3_replay_prdata", p_rdata, 32'hDEADBEEF);
    chk("t3_after_state", 32'(dut.state_q), 0);
    chk("t3_mem_written", mem[16], 32'hA5A5A5A5);
`ifdef DMEM_ARB_STATS_EN
    chk("t6_stat_stall", 32'(stat_stall_cnt), 1);
    chk("t6_stat_dbg", 32'(stat_dbg_cnt), 1);
`endif
    tick();

    // 4: enter FORCE with the debug request withdrawn
    d_req = 1; d_we = 0; d_addr = 9'h020;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("t4_deny_ready", 32'(d_ready), 0);
      tick();
    end
    d_req = 0;
    settle();
    chk("t4_force_state", 32'(dut.state_q), 1);
    chk("t4_force_ready", 32'(d_ready), 0);
    chk("t4_force_stall", 32'(p_stall), 0);
    chk("t4_force_m_re", 32'(m_re), 1);
    chk("t4_force_prdata", p_rdata, 32'hDEADBEEF);
    tick();
    settle();
    chk("t4_back_norm", 32'(dut.state_q), 0);
    chk("t4_no_rvalid", 32'(d_rvalid), 0);
    tick();

    // dropping d_req clears a partial starvation count
    d_req = 1;
    tick(); tick(); tick();
    d_req = 0;
    settle();
    chk("clr_cnt_before", 32'(dut.wait_cnt), 3);
    tick();
    settle();
    chk("clr_cnt_after", 32'(dut.wait_cnt), 0);
    tick();

    // 5: reset the cycle after a debug read accept
    p_re = 0;
    d_req = 1; d_we = 0; d_addr = 9'h020;
    settle();
    chk("t5_accept", 32'(d_ready), 1);
    tick();
    reset = 1; d_req = 0;
    settle();
    chk("t5_rvalid_dropped", 32'(d_rvalid), 0);
    chk("t5_rdata_cleared", d_rdata, 0);
    tick();
    settle();
    chk("t5_state", 32'(dut.state_q), 0);
    chk("t5_wait_cnt", 32'(dut.wait_cnt), 0);
    chk("t5_rvalid_rst", 32'(d_rvalid), 0);
    tick();
    reset = 0;
    settle();
    chk("t5_rvalid_post", 32'(d_rvalid), 0);
    chk("t5_rdata_post", d_rdata, 0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
